// File: rtl/in_port_pkg.sv
// in_port_pkg: shared types and default parameters for the IN-port source.
// Contents: debouncer state enum, default WIDTH / DEPTH / DB_CYCLES.
// Imported by in_port_debounce and in_port_source.
package in_port_pkg;

  // Debounced button level is high in HIGH and FALL_WAIT.
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } db_state_t;

  localparam int IN_PORT_WIDTH     = 32;
  localparam int IN_PORT_DEPTH     = 4;
  localparam int IN_PORT_DB_CYCLES = 16;

endpackage

// File: rtl/in_port_debounce.sv
// in_port_debounce: 2-FF synchronizer plus optional debounce FSM for the load button.
// Latency: 2 edges raw->synced; with IN_PORT_DEBOUNCE_EN a further DB_CYCLES edges to o_btn_db.
// Backpressure: none; free-running level filter.
// Ports: clk, reset (async active-low), i_btn_raw (asynchronous pushbutton), o_btn_db (debounced level).
// Macro IN_PORT_DEBOUNCE_EN selects the debounce FSM; undefined, o_btn_db is the synchronized level.
module in_port_debounce
  import in_port_pkg::*;
#(
  parameter int DB_CYCLES = IN_PORT_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_raw,
  output logic o_btn_db
);

  logic r_sync1;
  logic r_sync2;
  logic w_btn_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;

`ifdef IN_PORT_DEBOUNCE_EN
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  db_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_btn_db;

  // r_cnt holds the number of consecutive agreeing samples already seen in
  // a WAIT state; the sample that brings it to DB_CYCLES commits the change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= LOW;
      r_cnt    <= '0;
      r_btn_db <= 1'b0;
    end else begin
      case (r_state)
        LOW: begin
          if (w_btn_s) begin
            if (DB_CYCLES <= 1) begin
              r_state  <= HIGH;
              r_btn_db <= 1'b1;
              r_cnt    <= '0;
            end else begin
              r_state <= RISE_WAIT;
              r_cnt   <= CW'(1);
            end
          end
        end
        RISE_WAIT: begin
          if (!w_btn_s) begin
            r_state <= LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_state  <= HIGH;
            r_btn_db <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!w_btn_s) begin
            if (DB_CYCLES <= 1) begin
              r_state  <= LOW;
              r_btn_db <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_state <= FALL_WAIT;
              r_cnt   <= CW'(1);
            end
          end
        end
        FALL_WAIT: begin
          if (w_btn_s) begin
            r_state <= HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_state  <= LOW;
            r_btn_db <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= LOW;
          r_btn_db <= 1'b0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign o_btn_db = r_btn_db;
`else
  // DB_CYCLES has no effect in this build; tie it off so it is not flagged.
  logic w_unused_db;
  assign w_unused_db = (DB_CYCLES > 0);
  assign o_btn_db    = w_btn_s;
`endif

endmodule

// File: rtl/in_port_source.sv
// in_port_source: captures sw_data on each debounced load press into a FIFO feeding the CPU IN unit.
// Latency: raw press to in_valid is DB_CYCLES+3 edges (3 edges without IN_PORT_DEBOUNCE_EN); pop takes effect on the in_rd edge.
// Backpressure: push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
// Ports: clk, reset (async active-low), sw_data, load_btn, in_rd, clear (sync flush) ->
//        IN_unit_input (head, 0 when empty), in_valid, full, count, overflow.
// Macro IN_PORT_DEBOUNCE_EN enables the button debounce FSM (see in_port_debounce).
module in_port_source
  import in_port_pkg::*;
#(
  parameter int WIDTH     = IN_PORT_WIDTH,
  parameter int DEPTH     = IN_PORT_DEPTH,
  parameter int DB_CYCLES = IN_PORT_DB_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sw_data,
  input  logic                     load_btn,
  input  logic                     in_rd,
  input  logic                     clear,
  output logic [WIDTH-1:0]         IN_unit_input,
  output logic                     in_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              w_btn_db;
  logic              r_btn_db_d;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_valid;
  logic              w_wr_en;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  in_port_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .i_btn_raw (load_btn),
    .o_btn_db  (w_btn_db)
  );

  assign w_push  = w_btn_db & ~r_btn_db_d;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = in_rd & w_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // clear wins over everything, so the write is suppressed as well.
  assign w_wr_en = w_push & (~w_full | w_pop) & ~clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_db_d <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_btn_db_d <= w_btn_db;
      if (clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_wr_en && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_wr_en && w_pop) r_count <= r_count - 1'b1;
        if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is gated to 0 whenever count is 0.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= sw_data;
  end

  assign IN_unit_input = w_valid ? r_mem[r_rd_ptr] : '0;
  assign in_valid      = w_valid;
  assign full          = w_full;
  assign count         = r_count;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_in_port_source.sv
// tb_in_port_source: directed bench for in_port_source with default parameters.
// Latency: expectations follow the build (DB_CYCLES+3 edges debounced, 3 edges otherwise).
// Backpressure: exercised through full/overflow and simultaneous push/pop cases.
module tb_in_port_source;
  import in_port_pkg::*;

  localparam int WIDTH = IN_PORT_WIDTH;
  localparam int DEPTH = IN_PORT_DEPTH;

`ifdef IN_PORT_DEBOUNCE_EN
  localparam int LAT          = IN_PORT_DB_CYCLES + 3;
  localparam int BOUNCE_COUNT = 1;
  localparam int BOUNCE_OVF   = 0;
`else
  localparam int LAT          = 3;
  localparam int BOUNCE_COUNT = 4;  // six pushes from five bounces + final press, two dropped
  localparam int BOUNCE_OVF   = 1;
`endif

  logic                  clk;
  logic                  reset;
  logic [WIDTH-1:0]      sw_data;
  logic                  load_btn;
  logic                  in_rd;
  logic                  clear;
  logic [WIDTH-1:0]      IN_unit_input;
  logic                  in_valid;
  logic                  full;
  logic [$clog2(DEPTH):0] count;
  logic                  overflow;

  int n_vec = 0;
  int n_err = 0;

  in_port_source dut (
    .clk           (clk),
    .reset         (reset),
    .sw_data       (sw_data),
    .load_btn      (load_btn),
    .in_rd         (in_rd),
    .clear         (clear),
    .IN_unit_input (IN_unit_input),
    .in_valid      (in_valid),
    .full          (full),
    .count         (count),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [WIDTH-1:0] d, input int hold, input int rel);
    sw_data  = d;
    load_btn = 1'b1;
    tick(hold);
    load_btn = 1'b0;
    tick(rel);
  endtask

  task automatic pop_once();
    in_rd = 1'b1;
    tick(1);
    in_rd = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    sw_data  = '0;
    load_btn = 1'b0;
    in_rd    = 1'b0;
    clear    = 1'b0;
    tick(3);

    // Reset state
    check("rst_data",  IN_unit_input, 0);
    check("rst_valid", in_valid, 0);
    check("rst_full",  full, 0);
    check("rst_count", count, 0);
    check("rst_ovf",   overflow, 0);
    reset = 1'b1;
    tick(2);

    // Clean press: exact latency, single push for a long hold
    sw_data  = 32'hC0;
    load_btn = 1'b1;
    tick(LAT - 1);
    check("lat_before", in_valid, 0);
    tick(1);
    check("lat_valid", in_valid, 1);
    check("lat_data",  IN_unit_input, 32'hC0);
    check("lat_count", count, 1);
    tick(40 - LAT);
    load_btn = 1'b0;
    tick(40);
    check("hold_one_push", count, 1);
    pop_once();
    check("pop_empty_valid", in_valid, 0);
    check("pop_empty_data",  IN_unit_input, 0);
    check("pop_empty_count", count, 0);

    // Bouncing press: 5 bounces of 3 cycles, then stable
    sw_data = 32'h5A;
    for (int i = 0; i < 5; i++) begin
      load_btn = 1'b1;
      tick(3);
      load_btn = 1'b0;
      tick(3);
    end
    load_btn = 1'b1;
    tick(40);
    load_btn = 1'b0;
    tick(40);
    check("bounce_count", count, BOUNCE_COUNT);
    check("bounce_ovf",   overflow, BOUNCE_OVF);
    check("bounce_data",  IN_unit_input, 32'h5A);
    do_clear();
    check("clear_count", count, 0);
    check("clear_ovf",   overflow, 0);

    // Five presses into a 4-deep FIFO, then drain
    for (int i = 1; i <= 5; i++) press(WIDTH'(i), 30, 30);
    check("fill_count", count, 4);
    check("fill_full",  full, 1);
    check("fill_ovf",   overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_head%0d", i), IN_unit_input, i);
      pop_once();
    end
    check("drain_data",  IN_unit_input, 0);
    check("drain_valid", in_valid, 0);
    check("drain_ovf_sticky", overflow, 1);
    do_clear();

    // Full FIFO: push and pop on the same edge
    for (int i = 0; i < 4; i++) press(WIDTH'(32'h10 + i), 30, 30);
    check("pp_full_pre", full, 1);
    sw_data  = 32'h14;
    load_btn = 1'b1;
    tick(LAT - 1);
    in_rd = 1'b1;
    tick(1);
    in_rd = 1'b0;
    check("pp_count", count, 4);
    check("pp_ovf",   overflow, 0);
    check("pp_head",  IN_unit_input, 32'h11);
    tick(30 - LAT);
    load_btn = 1'b0;
    tick(30);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("pp_drain%0d", i), IN_unit_input, 32'h10 + i);
      pop_once();
    end
    check("pp_drained", count, 0);

    // in_rd on an empty FIFO is ignored
    pop_once();
    check("rd_empty_count", count, 0);
    check("rd_empty_valid", in_valid, 0);
    check("rd_empty_data",  IN_unit_input, 0);

    // clear on the same edge as a push into an overflowed FIFO
    for (int i = 0; i < 5; i++) press(WIDTH'(32'h20 + i), 30, 30);
    check("cp_ovf_pre", overflow, 1);
    sw_data  = 32'h30;
    load_btn = 1'b1;
    tick(LAT - 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("cp_count", count, 0);
    check("cp_ovf",   overflow, 0);
    check("cp_valid", in_valid, 0);
    tick(30 - LAT);
    load_btn = 1'b0;
    tick(30);
    check("cp_push_lost", count, 0);

    // Reset with 3 entries held and a debounce in progress
    for (int i = 0; i < 3; i++) press(WIDTH'(32'h7 + i), 30, 30);
    check("rm_count_pre", count, 3);
    sw_data  = 32'hAB;
    load_btn = 1'b1;
    tick(10);
    reset = 1'b0;
    #1;
    check("rm_data",  IN_unit_input, 0);
    check("rm_valid", in_valid, 0);
    check("rm_full",  full, 0);
    check("rm_count", count, 0);
    check("rm_ovf",   overflow, 0);
    tick(3);
    reset = 1'b1;
    tick(LAT - 1);
    check("rm_restart_before", in_valid, 0);
    tick(1);
    check("rm_restart_valid", in_valid, 1);
    check("rm_restart_data",  IN_unit_input, 32'hAB);
    load_btn = 1'b0;
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
